// File: rtl/receipt_integrity_checker.sv
// rtl/receipt_integrity_checker.sv - per-cycle mu-ledger receipt cost and chain verification
// Combinational verdicts gate acceptance in the same cycle; error_code is registered.
module receipt_integrity_checker #(
  parameter int unsigned DEFAULT_COST = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        receipt_valid,
  input  logic [31:0] receipt_pre_mu,
  input  logic [31:0] receipt_post_mu,
  input  logic [7:0]  receipt_opcode,
  input  logic [31:0] receipt_operand,
  input  logic        chain_mode,
  input  logic [31:0] prev_post_mu,
  output logic        receipt_integrity_ok,
  output logic        chain_continuity_ok,
  output logic [31:0] computed_cost,
  output logic [7:0]  error_code
);

  localparam logic [7:0] ERR_NONE     = 8'h00;
  localparam logic [7:0] ERR_COST     = 8'h01;
  localparam logic [7:0] ERR_DECREASE = 8'h02;
  localparam logic [7:0] ERR_CHAIN    = 8'h03;

  logic [31:0] base_cost;
  logic [31:0] delta;
  logic        no_decrease;
  logic        cost_match;
  logic        chain_match;
  logic [7:0]  error_code_d;
  logic [7:0]  error_code_q;

  always_comb begin
    base_cost = 32'(DEFAULT_COST);
    case (receipt_opcode)
      8'h00:   base_cost = 32'd1;
      8'h01:   base_cost = 32'd2;
      8'h02:   base_cost = 32'd2;
      8'h05:   base_cost = 32'd1;
      8'h06:   base_cost = 32'd4;
      8'hFF:   base_cost = 32'd0;
      default: base_cost = 32'(DEFAULT_COST);
    endcase
  end

  assign computed_cost = base_cost + {24'd0, receipt_operand[7:0]};
  assign delta         = receipt_post_mu - receipt_pre_mu;
  // A wrapped subtraction can alias a valid cost, so the explicit compare must gate it.
  assign no_decrease   = (receipt_post_mu >= receipt_pre_mu);
  assign cost_match    = no_decrease && (delta == computed_cost);
  assign chain_match   = !chain_mode || (receipt_pre_mu == prev_post_mu);

  assign receipt_integrity_ok = receipt_valid && cost_match;
  assign chain_continuity_ok  = receipt_valid && chain_match;

  always_comb begin
    error_code_d = error_code_q;
    if (receipt_valid) begin
      if (!no_decrease)      error_code_d = ERR_DECREASE;
      else if (!cost_match)  error_code_d = ERR_COST;
      else if (!chain_match) error_code_d = ERR_CHAIN;
      else                   error_code_d = ERR_NONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) error_code_q <= ERR_NONE;
    else        error_code_q <= error_code_d;
  end

  assign error_code = error_code_q;

endmodule

// File: tb/tb_receipt_integrity_checker.sv
// tb/tb_receipt_integrity_checker.sv - directed self-checking bench for receipt_integrity_checker
module tb_receipt_integrity_checker;

  logic        clk;
  logic        rst_n;
  logic        receipt_valid;
  logic [31:0] receipt_pre_mu;
  logic [31:0] receipt_post_mu;
  logic [7:0]  receipt_opcode;
  logic [31:0] receipt_operand;
  logic        chain_mode;
  logic [31:0] prev_post_mu;
  logic        receipt_integrity_ok;
  logic        chain_continuity_ok;
  logic [31:0] computed_cost;
  logic [7:0]  error_code;

  int errors = 0;
  int checks = 0;

  receipt_integrity_checker #(.DEFAULT_COST(1)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .receipt_valid        (receipt_valid),
    .receipt_pre_mu       (receipt_pre_mu),
    .receipt_post_mu      (receipt_post_mu),
    .receipt_opcode       (receipt_opcode),
    .receipt_operand      (receipt_operand),
    .chain_mode           (chain_mode),
    .prev_post_mu         (prev_post_mu),
    .receipt_integrity_ok (receipt_integrity_ok),
    .chain_continuity_ok  (chain_continuity_ok),
    .computed_cost        (computed_cost),
    .error_code           (error_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge, leaving half a cycle before the capturing edge.
  task automatic drive(input logic v, input logic [7:0] op, input logic [31:0] opnd,
                       input logic [31:0] pre, input logic [31:0] post,
                       input logic cm, input logic [31:0] prev);
    @(negedge clk);
    receipt_valid   = v;
    receipt_opcode  = op;
    receipt_operand = opnd;
    receipt_pre_mu  = pre;
    receipt_post_mu = post;
    chain_mode      = cm;
    prev_post_mu    = prev;
    #1;
  endtask

  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    receipt_valid = 1'b0; receipt_opcode = 8'h00; receipt_operand = 32'd0;
    receipt_pre_mu = 32'd0; receipt_post_mu = 32'd0; chain_mode = 1'b0; prev_post_mu = 32'd0;
    repeat (2) @(negedge clk);
    checks++;
    if (error_code !== 8'h00) begin
      errors++; $display("FAIL reset_error_code got=%h exp=00", error_code);
    end
    checks++;
    if (receipt_integrity_ok !== 1'b0 || chain_continuity_ok !== 1'b0) begin
      errors++; $display("FAIL reset_ok got=%b%b exp=00", receipt_integrity_ok, chain_continuity_ok);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_pnew();
    drive(1'b1, 8'h00, 32'h3, 32'd10, 32'd14, 1'b1, 32'd10);
    checks++;
    if (computed_cost !== 32'd4) begin
      errors++; $display("FAIL pnew_cost got=%0d exp=4", computed_cost);
    end
    checks++;
    if (receipt_integrity_ok !== 1'b1 || chain_continuity_ok !== 1'b1) begin
      errors++; $display("FAIL pnew_ok got=%b%b exp=11", receipt_integrity_ok, chain_continuity_ok);
    end
    next_edge();
    checks++;
    if (error_code !== 8'h00) begin
      errors++; $display("FAIL pnew_error_code got=%h exp=00", error_code);
    end
  endtask

  task automatic test_cost_mismatch();
    drive(1'b1, 8'h00, 32'h3, 32'd10, 32'd15, 1'b1, 32'd10);
    checks++;
    if (receipt_integrity_ok !== 1'b0 || chain_continuity_ok !== 1'b1) begin
      errors++; $display("FAIL mismatch_ok got=%b%b exp=01", receipt_integrity_ok, chain_continuity_ok);
    end
    next_edge();
    checks++;
    if (error_code !== 8'h01) begin
      errors++; $display("FAIL mismatch_error_code got=%h exp=01", error_code);
    end
  endtask

  task automatic test_decrease();
    drive(1'b1, 8'h01, 32'h0, 32'd20, 32'd10, 1'b1, 32'd20);
    checks++;
    if (receipt_integrity_ok !== 1'b0) begin
      errors++; $display("FAIL decrease_ok got=%b exp=0", receipt_integrity_ok);
    end
    next_edge();
    checks++;
    if (error_code !== 8'h02) begin
      errors++; $display("FAIL decrease_error_code got=%h exp=02", error_code);
    end
    // Wrapped delta equals PSPLIT cost of 2 yet must be rejected.
    drive(1'b1, 8'h01, 32'h0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF);
    checks++;
    if (computed_cost !== 32'd2 || receipt_integrity_ok !== 1'b0) begin
      errors++; $display("FAIL wrap_ok got=cost %0d ok %b exp=cost 2 ok 0", computed_cost, receipt_integrity_ok);
    end
    drive(1'b1, 8'h00, 32'h3, 32'd10, 32'd14, 1'b0, 32'd0);
    next_edge();
    drive(1'b1, 8'h01, 32'h0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF);
    next_edge();
    checks++;
    if (error_code !== 8'h02) begin
      errors++; $display("FAIL wrap_error_code got=%h exp=02", error_code);
    end
    drive(1'b1, 8'h01, 32'h0, 32'd20, 32'd10, 1'b1, 32'd5);
    checks++;
    if (receipt_integrity_ok !== 1'b0 || chain_continuity_ok !== 1'b0) begin
      errors++; $display("FAIL dec_chain_ok got=%b%b exp=00", receipt_integrity_ok, chain_continuity_ok);
    end
    next_edge();
    checks++;
    if (error_code !== 8'h02) begin
      errors++; $display("FAIL dec_chain_error_code got=%h exp=02", error_code);
    end
    drive(1'b1, 8'h01, 32'h0, 32'd20, 32'd30, 1'b1, 32'd5);
    next_edge();
    checks++;
    if (error_code !== 8'h01) begin
      errors++; $display("FAIL cost_chain_error_code got=%h exp=01", error_code);
    end
  endtask

  task automatic test_chain();
    drive(1'b1, 8'h06, 32'h10, 32'd100, 32'd120, 1'b1, 32'd99);
    checks++;
    if (computed_cost !== 32'd20) begin
      errors++; $display("FAIL pdisc_cost got=%0d exp=20", computed_cost);
    end
    checks++;
    if (receipt_integrity_ok !== 1'b1 || chain_continuity_ok !== 1'b0) begin
      errors++; $display("FAIL pdisc_ok got=%b%b exp=10", receipt_integrity_ok, chain_continuity_ok);
    end
    next_edge();
    checks++;
    if (error_code !== 8'h03) begin
      errors++; $display("FAIL pdisc_error_code got=%h exp=03", error_code);
    end
    drive(1'b1, 8'h06, 32'h10, 32'd100, 32'd120, 1'b0, 32'd99);
    checks++;
    if (chain_continuity_ok !== 1'b1) begin
      errors++; $display("FAIL nochain_ok got=%b exp=1", chain_continuity_ok);
    end
    next_edge();
    checks++;
    if (error_code !== 8'h00) begin
      errors++; $display("FAIL nochain_error_code got=%h exp=00", error_code);
    end
  endtask

  task automatic test_cost_table();
    logic [7:0]  ops   [6] = '{8'h42, 8'hFF, 8'h02, 8'h05, 8'h03, 8'h01};
    logic [31:0] opnds [6] = '{32'h5, 32'h0, 32'h0, 32'h0, 32'h0, 32'h1FF};
    logic [31:0] costs [6] = '{32'd6, 32'd0, 32'd2, 32'd1, 32'd1, 32'd257};
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, ops[i], opnds[i], 32'd0, 32'd0, 1'b0, 32'd0);
      checks++;
      if (computed_cost !== costs[i]) begin
        errors++; $display("FAIL cost_op%h got=%0d exp=%0d", ops[i], computed_cost, costs[i]);
      end
    end
    drive(1'b1, 8'hFF, 32'h0, 32'd7, 32'd7, 1'b0, 32'd0);
    checks++;
    if (receipt_integrity_ok !== 1'b1) begin
      errors++; $display("FAIL halt_ok got=%b exp=1", receipt_integrity_ok);
    end
    drive(1'b1, 8'h42, 32'h5, 32'd0, 32'd6, 1'b0, 32'd0);
    checks++;
    if (receipt_integrity_ok !== 1'b1) begin
      errors++; $display("FAIL unknown_ok got=%b exp=1", receipt_integrity_ok);
    end
    next_edge();
  endtask

  task automatic test_hold();
    drive(1'b1, 8'h00, 32'h3, 32'd10, 32'd15, 1'b1, 32'd10);
    next_edge();
    drive(1'b0, 8'h01, 32'h0, 32'd20, 32'd10, 1'b0, 32'd20);
    checks++;
    if (receipt_integrity_ok !== 1'b0 || chain_continuity_ok !== 1'b0) begin
      errors++; $display("FAIL hold_ok got=%b%b exp=00", receipt_integrity_ok, chain_continuity_ok);
    end
    checks++;
    if (computed_cost !== 32'd2) begin
      errors++; $display("FAIL hold_cost got=%0d exp=2", computed_cost);
    end
    next_edge();
    next_edge();
    checks++;
    if (error_code !== 8'h01) begin
      errors++; $display("FAIL hold_error_code got=%h exp=01", error_code);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (error_code !== 8'h00) begin
      errors++; $display("FAIL async_reset got=%h exp=00", error_code);
    end
    #1 rst_n = 1'b1;
    drive(1'b1, 8'h06, 32'h10, 32'd100, 32'd120, 1'b1, 32'd99);
    next_edge();
    checks++;
    if (error_code !== 8'h03) begin
      errors++; $display("FAIL post_reset_error_code got=%h exp=03", error_code);
    end
  endtask

  initial begin
    test_reset();
    test_pnew();
    test_cost_mismatch();
    test_decrease();
    test_chain();
    test_cost_table();
    test_hold();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
